iq_uart_framer: RTL and testbench

- Downstream of the PSK correlator dispatcher.
- Consumes the dispatcher's byte stream (value/rdy strobes), pairs consecutive bytes into one sample record and buffers records in a small FIFO.
- Serialises each record as a sync-prefixed 8N1 UART frame to the host link.
- Decouples correlator dump rate from UART bandwidth and flags lost records.

---
 rtl/iq_uart_framer.sv | 195 +++++++++++++++++++
 tb/tb_iq_uart_framer.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/iq_uart_framer.sv
// iq_uart_framer: pairs dispatcher bytes into 16-bit records {b0,b1}, buffers
// them in a small FIFO and sends each record as an 8N1 UART frame:
// SYNC_BYTE, b0, b1.
// Optional build macro IQ_UART_FRAMER_CHECKSUM_EN appends a fourth byte,
// b0 ^ b1, to every frame.
module iq_uart_framer #(
  parameter int unsigned CLK_DIV   = 104,
  parameter int unsigned FIFO_AW   = 4,
  parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [7:0]         value,
  input  logic               rdy,
  output logic               tx,
  output logic               busy,
  output logic               overflow,
  output logic [FIFO_AW:0]   level
);

  localparam int unsigned     DEPTH     = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0] DEPTH_L  = {1'b1, {FIFO_AW{1'b0}}};
  localparam logic [15:0]     BAUD_LAST = 16'(CLK_DIV - 1);

`ifdef IQ_UART_FRAMER_CHECKSUM_EN
  typedef enum logic [2:0] {S_IDLE, S_SYNC, S_BYTE0, S_BYTE1, S_CSUM} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_SYNC, S_BYTE0, S_BYTE1} state_t;
`endif

  // Pairing stage
  logic               phase_q;
  logic [7:0]         b0_q;
  logic [15:0]        pair_q;
  logic               push_q;

  // FIFO
  logic [15:0]        mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr_q;
  logic [FIFO_AW-1:0] rd_ptr_q;
  logic [FIFO_AW:0]   level_q;
  logic               overflow_q;
  logic               full;
  logic               push_ok;
  logic               pop;
  logic [15:0]        rec_q;

  // Transmitter
  state_t             state_q, state_d;
  logic [15:0]        baud_q, baud_d;
  logic [3:0]         bit_q, bit_d;
  logic [9:0]         frame_q, frame_d;
  logic               busy_q, busy_d;
  logic               last_byte;

  // A full FIFO still accepts a push when the transmitter pops in the same cycle.
  assign full    = (level_q == DEPTH_L);
  assign push_ok = push_q && (!full || pop);

  // Collect two bytes into a record; the record is pushed on the following edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_q <= 1'b0;
      b0_q    <= 8'h00;
      pair_q  <= 16'h0000;
      push_q  <= 1'b0;
    end else begin
      push_q <= 1'b0;
      if (rdy) begin
        if (!phase_q) begin
          b0_q    <= value;
          phase_q <= 1'b1;
        end else begin
          pair_q  <= {b0_q, value};
          push_q  <= 1'b1;
          phase_q <= 1'b0;
        end
      end
    end
  end

  // RAM write port; left unreset so it maps onto memory primitives.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_q] <= pair_q;
  end

  // Registered read port: the popped record lands in rec_q. When full with a
  // simultaneous push the read sees the old contents, which is the record we want.
  always_ff @(posedge clk) begin
    if (pop) rec_q <= mem[rd_ptr_q];
  end

  // FIFO pointers, occupancy and the sticky lost-record flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)     rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push_ok && !pop)      level_q <= level_q + 1'b1;
      else if (!push_ok && pop) level_q <= level_q - 1'b1;
      if (push_q && !push_ok)   overflow_q <= 1'b1;
    end
  end

  // Transmitter state register; frame_q[0] drives tx directly so it never glitches.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      baud_q  <= 16'h0000;
      bit_q   <= 4'd0;
      frame_q <= '1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      frame_q <= frame_d;
      busy_q  <= busy_d;
    end
  end

  // Next-state logic: bit timing, byte sequencing and back-to-back frame chaining.
  always_comb begin
    state_d   = state_q;
    baud_d    = baud_q;
    bit_d     = bit_q;
    frame_d   = frame_q;
    busy_d    = busy_q;
    pop       = 1'b0;
    last_byte = 1'b0;

    if (state_q == S_IDLE) begin
      if (level_q != '0) begin
        pop     = 1'b1;
        frame_d = {1'b1, SYNC_BYTE, 1'b0};
        baud_d  = 16'h0000;
        bit_d   = 4'd0;
        state_d = S_SYNC;
        busy_d  = 1'b1;
      end
    end else if (baud_q != BAUD_LAST) begin
      baud_d = baud_q + 16'd1;
    end else begin
      baud_d = 16'h0000;
      if (bit_q != 4'd9) begin
        bit_d   = bit_q + 4'd1;
        frame_d = {1'b1, frame_q[9:1]};
      end else begin
        bit_d = 4'd0;
        case (state_q)
          S_SYNC: begin
            frame_d = {1'b1, rec_q[15:8], 1'b0};
            state_d = S_BYTE0;
          end
          S_BYTE0: begin
            frame_d = {1'b1, rec_q[7:0], 1'b0};
            state_d = S_BYTE1;
          end
`ifdef IQ_UART_FRAMER_CHECKSUM_EN
          S_BYTE1: begin
            frame_d = {1'b1, rec_q[15:8] ^ rec_q[7:0], 1'b0};
            state_d = S_CSUM;
          end
          S_CSUM: last_byte = 1'b1;
`else
          S_BYTE1: last_byte = 1'b1;
`endif
          default: state_d = S_IDLE;
        endcase
        // End of the final stop bit: chain straight into the next frame if one waits.
        if (last_byte) begin
          if (level_q != '0) begin
            pop     = 1'b1;
            frame_d = {1'b1, SYNC_BYTE, 1'b0};
            state_d = S_SYNC;
          end else begin
            frame_d = '1;
            state_d = S_IDLE;
            busy_d  = 1'b0;
          end
        end
      end
    end
  end

  assign tx       = frame_q[0];
  assign busy     = busy_q;
  assign overflow = overflow_q;
  assign level    = level_q;

endmodule

// File: tb/tb_iq_uart_framer.sv
`timescale 1ns/1ps
// Scoreboard bench for iq_uart_framer: a record-level reference model predicts
// FIFO occupancy, busy, overflow and every frame; a UART decoder on tx checks
// frame contents and start times.
module tb_iq_uart_framer;
  localparam int D     = 4;
  localparam int AW    = 2;
  localparam int DEPTH = 4;
  localparam logic [7:0] SYNC = 8'hA5;
`ifdef IQ_UART_FRAMER_CHECKSUM_EN
  localparam int NB = 4;
`else
  localparam int NB = 3;
`endif
  localparam int FRAME_CLKS = NB * 10 * D;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          rdy = 1'b0;
  logic [7:0]    value = 8'h00;
  logic          tx, busy, overflow;
  logic [AW:0]   level;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int          start;
    logic [31:0] bytes;   // wire order, first byte in [7:0]
  } frame_t;

  frame_t exp_q[$];

  iq_uart_framer #(.CLK_DIV(D), .FIFO_AW(AW), .SYNC_BYTE(SYNC)) dut (
    .clk(clk), .rst(rst), .value(value), .rdy(rdy),
    .tx(tx), .busy(busy), .overflow(overflow), .level(level)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  // Reference model: records move pairing -> queue -> transmitter with the
  // documented latencies; one frame occupies FRAME_CLKS cycles.
  initial begin : model
    int          cyc;
    logic [15:0] fifo[$];
    bit          m_busy, m_phase, m_pend, m_ovf, do_pop;
    int          m_end;
    logic [7:0]  m_b0;
    logic [15:0] m_rec, r;
    frame_t      f;
    cyc = 0; m_busy = 0; m_phase = 0; m_pend = 0; m_ovf = 0; m_end = 0;
    m_b0 = 8'h00; m_rec = 16'h0000;
    forever begin
      @(negedge clk);
      if (rst) begin
        fifo.delete(); exp_q.delete();
        m_busy = 0; m_phase = 0; m_pend = 0; m_ovf = 0;
      end else begin
        check("level", 32'(level), 32'(fifo.size()));
        check("busy", 32'(busy), 32'(m_busy));
        check("overflow", 32'(overflow), 32'(m_ovf));
        if (!m_busy) check("tx_idle", 32'(tx), 32'd1);
        do_pop = (fifo.size() > 0) && (!m_busy || cyc == m_end);
        if (do_pop) begin
          r = fifo.pop_front();
          f.start = cyc + 1;
          f.bytes = {(NB == 4) ? (r[15:8] ^ r[7:0]) : 8'h00, r[7:0], r[15:8], SYNC};
          exp_q.push_back(f);
          m_busy = 1;
          m_end  = cyc + FRAME_CLKS;
        end else if (m_busy && cyc == m_end) begin
          m_busy = 0;
        end
        if (m_pend) begin
          if (fifo.size() < DEPTH) fifo.push_back(m_rec);
          else m_ovf = 1;
        end
        m_pend = 0;
        if (rdy) begin
          if (!m_phase) begin m_b0 = value; m_phase = 1; end
          else begin m_rec = {m_b0, value}; m_pend = 1; m_phase = 0; end
        end
      end
      cyc++;
    end
  end

  // Monitor: decodes tx mid-bit and checks each frame against the scoreboard.
  initial begin : monitor
    int          cyc, start, off, bp;
    bit          in_f;
    logic [31:0] got;
    frame_t      e;
    cyc = 0; in_f = 0; got = '0; start = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        in_f = 0;
      end else begin
        if (!in_f && tx == 1'b0) begin
          in_f = 1; start = cyc; got = '0;
        end
        if (in_f) begin
          off = cyc - start;
          if (off % D == D / 2) begin
            bp = off / D;
            if (bp % 10 == 0)      check("start_bit", 32'(tx), 32'd0);
            else if (bp % 10 == 9) check("stop_bit", 32'(tx), 32'd1);
            else                   got[8 * (bp / 10) + (bp % 10) - 1] = tx;
            if (bp == NB * 10 - 1) begin
              in_f = 0;
              if (exp_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_frame: got %0h expected none", got);
              end else begin
                e = exp_q.pop_front();
                check("frame_start", 32'(start), 32'(e.start));
                check("frame_bytes", got, e.bytes);
              end
            end
          end
        end
      end
      cyc++;
    end
  end

  task automatic step(input logic r, input logic [7:0] v);
    rdy = r; value = v;
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00);
  endtask

  task automatic send(input logic [7:0] a, input logic [7:0] b);
    step(1'b1, a); step(1'b1, b); step(1'b0, 8'h00);
  endtask

  // Asynchronous reset pulse between edges; outputs must clear before the next edge.
  task automatic pulse_rst();
    rdy = 1'b0;
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    check("rst_tx", 32'(tx), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_level", 32'(level), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin : driver
    int p;
    repeat (3) @(posedge clk);
    #1;
    check("init_tx", 32'(tx), 32'd1);
    check("init_busy", 32'(busy), 32'd0);
    check("init_level", 32'(level), 32'd0);
    check("init_overflow", 32'(overflow), 32'd0);
    rst = 1'b0;
    idle(5);

    // Single record, then three back-to-back records.
    send(8'h12, 8'h34);
    idle(FRAME_CLKS + 20);
    for (int i = 0; i < 6; i++) step(1'b1, 8'(8'h40 + i));
    step(1'b0, 8'h00);
    idle(3 * FRAME_CLKS + 20);

    // Checksum pattern (plain frame when the option is off).
    send(8'hF0, 8'h0F);
    idle(FRAME_CLKS + 20);

    // Overflow burst: six records into a depth-4 FIFO.
    for (int i = 0; i < 12; i++) step(1'b1, 8'($urandom));
    step(1'b0, 8'h00);
    idle(6 * FRAME_CLKS);
    check("overflow_sticky", 32'(overflow), 32'd1);

    // Reset during BYTE0 data bits with a second record buffered.
    send(8'h11, 8'h22);
    send(8'h33, 8'h44);
    idle(10 * D + 6);
    pulse_rst();
    step(1'b1, 8'h77);
    step(1'b0, 8'h00);
    idle(FRAME_CLKS + 20);
    pulse_rst();

    // Odd byte count: the stray byte is discarded by reset.
    step(1'b1, 8'hAA);
    step(1'b0, 8'h00);
    pulse_rst();
    send(8'h01, 8'h02);
    idle(FRAME_CLKS + 20);

    // Random traffic: sparse, then dense enough to overflow.
    for (int i = 0; i < 3000; i++) begin
      p = $urandom_range(0, 63);
      step(p == 0, 8'($urandom));
    end
    for (int i = 0; i < 2000; i++) begin
      p = $urandom_range(0, 7);
      step(p == 0, 8'($urandom));
    end
    idle(8 * FRAME_CLKS);
    check("pending_frames", 32'(exp_q.size()), 32'd0);
    check("final_busy", 32'(busy), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
